// File: rtl/arb_pkg.sv
// Shared types and constants for the 32-way round-robin arbiter.
package arb_pkg;

  localparam int ARB_N     = 32;
  localparam int ARB_PTR_W = 5;

  typedef logic [ARB_N-1:0]     req_vec_t;
  typedef logic [ARB_PTR_W-1:0] arb_idx_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick_32.sv
// Combinational rotated-priority picker: the first set bit of req at or
// after ptr (wrapping 31->0) wins. Output is one-hot, its index, and any.
module rr_pick_32
  import arb_pkg::*;
(
  input  req_vec_t req,
  input  arb_idx_t ptr,
  output req_vec_t onehot,
  output arb_idx_t idx,
  output logic     any
);

  logic [2*ARB_N-1:0] dbl_req;
  logic [2*ARB_N-1:0] dbl_oh;
  req_vec_t           rot;
  req_vec_t           rot_oh;

  // Rotate right so ptr lands on bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    dbl_req = {req, req} >> ptr;
    rot     = dbl_req[ARB_N-1:0];
    rot_oh  = rot & (~rot + req_vec_t'(1));
    dbl_oh  = {rot_oh, rot_oh} << ptr;
    onehot  = dbl_oh[2*ARB_N-1:ARB_N];
    any     = |req;
  end

  // Encode the one-hot winner; at most one bit is set, so OR-ing indices is exact.
  always_comb begin
    idx = '0;
    for (int i = 0; i < ARB_N; i++) begin
      if (onehot[i]) idx = idx | arb_idx_t'(i);
    end
  end

endmodule

// File: rtl/rr_arbiter_32.sv
// 32-requester round-robin arbiter with a registered one-hot grant and a
// valid/ready handshake. A grant is sticky until accepted; on acceptance
// the pointer moves past the winner and the same cycle's requests are
// re-arbitrated so back-to-back grants carry no bubble.
module rr_arbiter_32
  import arb_pkg::*;
#(
  parameter int N     = 32,
  parameter int PTR_W = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  input  logic           gnt_ready
);

  // The downstream encoder is fixed at 32 inputs.
  if (N != ARB_N || PTR_W != ARB_PTR_W) begin : g_bad_width
    $error("rr_arbiter_32: N must be 32 and PTR_W must be 5");
  end

  arb_state_t state_q, state_d;
  arb_idx_t   ptr_q, ptr_d;
  arb_idx_t   win_q, win_d;
  req_vec_t   gnt_q, gnt_d;

  arb_idx_t   pick_ptr;
  req_vec_t   pick_oh;
  arb_idx_t   pick_idx;
  logic       pick_any;
  logic       hs;

  assign hs = (state_q == GRANT) && gnt_ready;

  // While granting, the picker already looks from win+1 so its result is the
  // next winner if the handshake lands; in IDLE ptr equals that same value.
  assign pick_ptr = (state_q == GRANT) ? arb_idx_t'(win_q + arb_idx_t'(1)) : ptr_q;

  rr_pick_32 u_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Next-state, pointer and grant update.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_oh;
          win_d   = pick_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (hs) begin
          ptr_d = arb_idx_t'(win_q + arb_idx_t'(1));
          if (pick_any) begin
            gnt_d = pick_oh;
            win_d = pick_idx;
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset drops any in-flight grant immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = (state_q == GRANT);

  // The encoder downstream must never see a multi-hot vector.
  a_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(gnt_q) && (gnt_valid == (|gnt_q)));

endmodule

// File: tb/tb_rr_arbiter_32.sv
// Self-checking bench for rr_arbiter_32: directed scenarios plus random
// traffic, all compared against a rule-level round-robin model.
module tb_rr_arbiter_32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req;
  logic [31:0] gnt;
  logic        gnt_valid;
  logic        gnt_ready;

  int tests  = 0;
  int failed = 0;

  // Reference model state
  bit       m_valid;
  int       m_win;
  int       m_ptr;

  rr_arbiter_32 dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_ready (gnt_ready)
  );

  always #5 clk = ~clk;

  // First requester at or after p in wrap-around order, or -1.
  function automatic int first_from(input logic [31:0] r, input int p);
    for (int k = 0; k < 32; k++) begin
      if (r[(p + k) % 32]) return (p + k) % 32;
    end
    return -1;
  endfunction

  function automatic logic [31:0] model_gnt();
    logic [31:0] g;
    g = '0;
    if (m_valid) g[m_win] = 1'b1;
    return g;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_win   = 0;
    m_ptr   = 0;
  endtask

  // What one rising edge does under the rules.
  task automatic model_edge(input logic [31:0] r, input logic rdy);
    int w;
    if (!m_valid) begin
      w = first_from(r, m_ptr);
      if (w >= 0) begin
        m_valid = 1;
        m_win   = w;
      end
    end else if (rdy) begin
      m_ptr = (m_win + 1) % 32;
      w = first_from(r, m_ptr);
      if (w >= 0) m_win = w;
      else        m_valid = 0;
    end
  endtask

  // One clock: drive at negedge, edge, check at the next negedge.
  task automatic step(input logic [31:0] r, input logic rdy, input string name);
    logic [31:0] eg;
    req       = r;
    gnt_ready = rdy;
    @(posedge clk);
    model_edge(r, rdy);
    @(negedge clk);
    eg = model_gnt();
    tests++;
    if (gnt !== eg || gnt_valid !== m_valid) begin
      failed++;
      $display("FAIL %s: gnt=%h valid=%b expected gnt=%h valid=%b", name, gnt, gnt_valid, eg, m_valid);
    end
    tests++;
    if (!$onehot0(gnt) || gnt_valid !== (|gnt)) begin
      failed++;
      $display("FAIL %s_invariant: gnt=%h valid=%b", name, gnt, gnt_valid);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req       = '0;
    gnt_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic expect_gnt(input logic [31:0] exp, input string name);
    tests++;
    if (gnt !== exp) begin
      failed++;
      $display("FAIL %s: gnt=%h expected %h", name, gnt, exp);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (gnt !== 32'h0 || gnt_valid !== 1'b0) begin
      failed++;
      $display("FAIL reset_state: gnt=%h valid=%b expected 0/0", gnt, gnt_valid);
    end
    step(32'h8, 1'b0, "reset_pre_grant");
    // Assert reset between edges while the grant is outstanding.
    #2 rst = 1'b1;
    #1;
    model_reset();
    tests++;
    if (gnt !== 32'h0 || gnt_valid !== 1'b0) begin
      failed++;
      $display("FAIL reset_async: gnt=%h valid=%b expected 0/0", gnt, gnt_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step(32'h0, 1'b1, "reset_idle");
  endtask

  task automatic test_single_latency();
    do_reset();
    step(32'h100, 1'b0, "single_first");
    expect_gnt(32'h100, "single_latency");
    for (int i = 0; i < 5; i++) begin
      step(32'h100, 1'b0, "single_hold");
      expect_gnt(32'h100, "single_stable");
    end
    step(32'h0, 1'b1, "single_accept");
    // Pointer now 9: requester 9 beats requester 8.
    step(32'h300, 1'b0, "single_ptr9");
    expect_gnt(32'h200, "single_ptr9_winner");
  endtask

  task automatic test_full_wrap();
    logic [31:0] e;
    do_reset();
    for (int i = 0; i < 33; i++) begin
      step(32'hFFFF_FFFF, 1'b1, "wrap");
      e = 32'h1 << (i % 32);
      expect_gnt(e, "wrap_order");
    end
  endtask

  task automatic test_rotation_skip();
    logic [31:0] pend;
    logic [31:0] exp_seq [4];
    exp_seq[0] = 32'h4000_0000;
    exp_seq[1] = 32'h0000_0001;
    exp_seq[2] = 32'h0000_0004;
    exp_seq[3] = 32'h0000_0000;
    do_reset();
    step(32'h2000_0000, 1'b0, "skip_setup");
    step(32'h0, 1'b1, "skip_setup_accept");
    pend = 32'h4000_0005;
    for (int i = 0; i < 4; i++) begin
      step(pend, 1'b1, "skip");
      expect_gnt(exp_seq[i], "skip_order");
      pend = pend & ~gnt;
    end
  endtask

  task automatic test_sticky();
    do_reset();
    step(32'h10, 1'b0, "sticky_grant");
    for (int i = 0; i < 3; i++) begin
      step(32'h0, 1'b0, "sticky_withdrawn");
      expect_gnt(32'h10, "sticky_hold");
    end
    step(32'h0, 1'b1, "sticky_accept");
    step(32'h30, 1'b0, "sticky_ptr5");
    expect_gnt(32'h20, "sticky_ptr5_winner");
  endtask

  task automatic test_sole_repeat();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(32'h8000_0000, 1'b1, "sole");
      expect_gnt(32'h8000_0000, "sole_const");
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 3))
        0: r = '0;
        1: r = $urandom & $urandom & $urandom;
        2: r = 32'h1 << $urandom_range(0, 31);
        default: r = $urandom;
      endcase
      step(r, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    rst       = 1'b1;
    req       = '0;
    gnt_ready = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_single_latency();
    test_full_wrap();
    test_rotation_skip();
    test_sticky();
    test_sole_repeat();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_32.md
Name: rr_arbiter_32

Overview:
- 32-requester round-robin arbiter; sits directly upstream of the team's 32-to-5 one-hot encoder.
- Registered one-hot grant plus valid/ready handshake; `gnt` feeds the encoder input, and the downstream stage consumes the encoded index.
- Guarantees `gnt` is exactly one-hot or all-zero, so the encoder never sees multi-hot input.

Parameters:
- N, 32, number of requesters; fixed at 32 to match encoder width (elaboration error if N != 32).
- PTR_W, 5, pointer width, equals clog2(N).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  32  level request vector, bit i = requester i
- gnt  output  32  registered one-hot grant, valid when gnt_valid=1, all-zero otherwise
- gnt_valid  output  1  grant presented to downstream
- gnt_ready  input  1  downstream accepts grant (handshake = gnt_valid & gnt_ready)

Behaviour:
- Reset (async assert, rst=1): gnt=32'h0, gnt_valid=0, ptr=0, state=IDLE. Outputs go to reset values immediately on rst assertion, including mid-grant; an in-flight grant is dropped, not completed.
- Release: synchronous to clk; first arbitration occurs on the first rising edge with rst=0.
- Priority:
  - Requester `ptr` is highest priority, then ptr+1, …, wrapping 31→0, ending at ptr-1.
  - Pointer arithmetic is modulo 32 (5-bit natural wrap).
- States: IDLE, GRANT.
- IDLE:
  - gnt_valid=0, gnt=0.
  - If |req on a clock edge: winner w = first set bit from ptr in rotated order; gnt<=onehot(w), gnt_valid<=1, go GRANT.
  - If req=0: stay IDLE.
- Latency: req high in cycle k → gnt_valid high in cycle k+1 (one register stage).
- GRANT:
  - gnt and gnt_valid held stable while gnt_ready=0; no re-arbitration.
  - The grant is sticky: withdrawing req[w] does not revoke it.
- Handshake (gnt_valid & gnt_ready on an edge):
  - ptr<=w+1 mod 32.
  - Simultaneously arbitrate the current req using the new pointer, i.e. the same cycle's req with priority starting at w+1.
  - If any bit is set: load new onehot winner, stay GRANT (back-to-back grants, no bubble).
  - Else: gnt<=0, gnt_valid<=0, go IDLE.
  - The just-granted requester is lowest priority and wins again only if it is the sole requester.
- Fairness: with all 32 requesting continuously and gnt_ready=1, grants cycle 0,1,…,31,0 with one grant per clock.
- No handshake: ptr does not advance; ptr changes only on handshake.
- gnt_ready while gnt_valid=0: ignored.
- Invariant (assert in RTL/bench): $onehot0(gnt) always; gnt_valid == |gnt.

Decomposition:
- Shared package arb_pkg:
  - localparam ARB_N=32, ARB_PTR_W=5.
  - typedef logic [31:0] req_vec_t; typedef logic [4:0] arb_idx_t.
  - enum {IDLE, GRANT} arb_state_t.
- Sub-module rr_pick_32: purely combinational rotated priority picker (inputs req, ptr; outputs onehot winner, index w, any).
  - Rotate req right by ptr, run a fixed LSB-first priority, rotate the result back.
  - The arbiter instantiates it once and uses it in both IDLE and the handshake path.

Test Plan:
1. Reset/idle: assert rst mid-stream with gnt_valid=1 → gnt=0, gnt_valid=0 asynchronously. Release with req=0 → remains IDLE for 10 cycles.
2. Single request, latency:
   - req=32'h00000100 at cycle k → gnt=32'h00000100, gnt_valid=1 at k+1.
   - Hold gnt_ready=0 for 5 cycles → gnt stable.
   - gnt_ready=1 → ptr=9. With req cleared, next cycle → gnt_valid=0.
3. Full round-robin wrap:
   - req=32'hFFFFFFFF, gnt_ready=1 from reset → 33 consecutive grants 32'h1, 32'h2, …, 32'h80000000, 32'h1.
   - No idle cycles.
4. Rotation skip: ptr=30, req=32'h40000005 → grants in order 32'h40000000, 32'h1, 32'h4, then IDLE.
5. Sticky grant under withdrawal:
   - req=32'h10 granted; drop req to 0 while gnt_ready=0 → gnt stays 32'h10.
   - On ready → gnt_valid=0, ptr=5.
6. Sole repeat requester: req=32'h80000000 held, gnt_ready=1 → granted every cycle. ptr alternates 0 (after wrap), gnt constant 32'h80000000, and $onehot0 never violated.
